// File: rtl/mem_arbiter_if.sv
// Bundle of requester-side and memory-side signals around the memory arbiter.
interface mem_arbiter_if #(
  parameter int unsigned XLEN = 32
);
  // Instruction fetch requester (read-only)
  logic            ifu_req;
  logic [XLEN-1:0] ifu_addr;
  logic            ifu_ack;
  logic [XLEN-1:0] ifu_rdata;

  // Execute requester (load/store)
  logic            ex_req;
  logic            ex_we;
  logic [XLEN-1:0] ex_addr;
  logic [XLEN-1:0] ex_wdata;
  logic            ex_ack;
  logic [XLEN-1:0] ex_rdata;

  // Timeout indication, pulses with the ack of an aborted transaction
  logic            err;

  // Memory port
  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_ready;
  logic [XLEN-1:0] mem_rdata;

  // Arbiter side
  modport slave (
    input  ifu_req, ifu_addr,
    output ifu_ack, ifu_rdata,
    input  ex_req, ex_we, ex_addr, ex_wdata,
    output ex_ack, ex_rdata,
    output err,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata
  );

  // Environment side (requesters plus memory)
  modport master (
    output ifu_req, ifu_addr,
    input  ifu_ack, ifu_rdata,
    output ex_req, ex_we, ex_addr, ex_wdata,
    input  ex_ack, ex_rdata,
    input  err,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Memory port arbiter between instruction fetch and execute.
// One transaction in flight at a time; ex has fixed priority, bounded by a
// starvation limit so that a waiting fetch is eventually forced through.
// A transaction with no mem_ready for TIMEOUT busy cycles completes with err.
module mem_arbiter #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 16
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_EX = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   streak_q, streak_d;
  logic [TW-1:0]   timer_q, timer_d;

  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
  logic            ifu_ack_q, ifu_ack_d;
  logic            ex_ack_q, ex_ack_d;
  logic            err_q, err_d;
  logic [XLEN-1:0] ifu_rdata_q, ifu_rdata_d;
  logic [XLEN-1:0] ex_rdata_q, ex_rdata_d;

  logic            ifu_pend_c;
  logic            ex_pend_c;
  logic            grant_ex_c;
  logic            grant_if_c;
  logic            timeout_c;

  // A requester being acked this cycle is masked so its held request is not reissued
  assign ifu_pend_c = bus.ifu_req && !ifu_ack_q;
  assign ex_pend_c  = bus.ex_req && !ex_ack_q;

  // ex wins unless fetch is waiting and ex has used up its streak
  assign grant_ex_c = ex_pend_c && (!ifu_pend_c || (streak_q != SW'(STARVE_LIMIT)));
  assign grant_if_c = ifu_pend_c && !grant_ex_c;

  assign timeout_c  = (timer_q == TW'(TIMEOUT - 1));

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    timer_d     = timer_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    ifu_ack_d   = 1'b0;
    ex_ack_d    = 1'b0;
    err_d       = 1'b0;
    ifu_rdata_d = ifu_rdata_q;
    ex_rdata_d  = ex_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (grant_ex_c) begin
          state_d     = BUSY_EX;
          timer_d     = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = bus.ex_we;
          mem_addr_d  = bus.ex_addr;
          mem_wdata_d = bus.ex_wdata;
          if (ifu_pend_c) begin
            streak_d = (streak_q == SW'(STARVE_LIMIT)) ? streak_q : streak_q + SW'(1);
          end else begin
            streak_d = '0;
          end
        end else if (grant_if_c) begin
          state_d     = BUSY_IF;
          timer_d     = '0;
          streak_d    = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = bus.ifu_addr;
          mem_wdata_d = '0;
        end
      end

      BUSY_IF, BUSY_EX: begin
        if (bus.mem_ready || timeout_c) begin
          state_d   = IDLE;
          timer_d   = '0;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          err_d     = !bus.mem_ready;
          if (state_q == BUSY_IF) begin
            ifu_ack_d   = 1'b1;
            ifu_rdata_d = bus.mem_ready ? bus.mem_rdata : '0;
          end else begin
            ex_ack_d   = 1'b1;
            ex_rdata_d = (bus.mem_ready && !mem_we_q) ? bus.mem_rdata : '0;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      streak_q    <= '0;
      timer_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ifu_ack_q   <= 1'b0;
      ex_ack_q    <= 1'b0;
      err_q       <= 1'b0;
      ifu_rdata_q <= '0;
      ex_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      timer_q     <= timer_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ifu_ack_q   <= ifu_ack_d;
      ex_ack_q    <= ex_ack_d;
      err_q       <= err_d;
      ifu_rdata_q <= ifu_rdata_d;
      ex_rdata_q  <= ex_rdata_d;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.ifu_ack   = ifu_ack_q;
  assign bus.ex_ack    = ex_ack_q;
  assign bus.err       = err_q;
  assign bus.ifu_rdata = ifu_rdata_q;
  assign bus.ex_rdata  = ex_rdata_q;

endmodule
